// File: rtl/dmem_if.sv
// Request/response bundle between the D-cache controller (master) and the
// backing data memory (slave).
interface dmem_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Backing data memory for D-cache refill/writeback: fixed-latency reads and
// posted writes through a single-entry write buffer with read forwarding.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rd_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              wr_acc;
  logic              drain;
  logic [DATA_W-1:0] rd_sel_d;

  // A full write buffer only blocks writes; reads may still be accepted.
  assign bus.req_ready = (state_q == IDLE) && !(bus.req_we && wb_valid_q);
  assign rd_acc        = bus.req_valid && bus.req_ready && !bus.req_we;
  assign wr_acc        = bus.req_valid && bus.req_ready &&  bus.req_we;

  // Single-ported array: the buffer drains only on edges with no read access.
  assign drain         = wb_valid_q && !rd_acc;

  assign rd_sel_d = (wb_valid_q && (wb_addr_q == bus.req_addr)) ? wb_data_q
                                                                : mem[bus.req_addr];

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.busy       = (state_q == WAIT) || wb_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      rd_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      wb_valid_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_acc) begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
            rd_q    <= rd_sel_d;
          end
        end
        WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= rd_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (wr_acc) begin
        wb_valid_q <= 1'b1;
      end else if (drain) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  // Buffer payload and array contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      wb_addr_q <= bus.req_addr;
      wb_data_q <= bus.req_wdata;
    end
    if (drain) begin
      mem[wb_addr_q] <= wb_data_q;
    end
  end

endmodule
